// File: rtl/regfile_seq_pkg.sv
// Shared types and timing defaults for the 74x670 bank access sequencer.
// Holds the state encodings, default pin-timing constants and timer helpers.
package regfile_seq_pkg;

    localparam int RF_ADDR_W = 2;

    localparam int DEF_SETUP  = 1;
    localparam int DEF_PULSE  = 2;
    localparam int DEF_HOLD   = 1;
    localparam int DEF_ACCESS = 2;

    // Wide enough for phase lengths up to 16 cycles.
    localparam int TIMER_W = 4;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_STALL,
        R_ACCESS,
        R_DONE
    } rd_state_e;

    // A phase of n cycles loads n-1; the state exits on the edge where the count is zero.
    function automatic logic [TIMER_W-1:0] cycles_to_load(input int n);
        return TIMER_W'(n - 1);
    endfunction

endpackage

// File: rtl/regfile_seq_timer.sv
// Loadable down-counter with a zero flag; measures the length of one FSM phase.
module regfile_seq_timer
    import regfile_seq_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/regfile_seq.sv
// Sequencer turning valid/ready read and write requests into timed 74x670 pin activity,
// with concurrent read/write ports and a same-address hazard interlock.
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SETUP  = DEF_SETUP,
    parameter int PULSE  = DEF_PULSE,
    parameter int HOLD   = DEF_HOLD,
    parameter int ACCESS = DEF_ACCESS
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [RF_ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,

    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [RF_ADDR_W-1:0] rd_addr,
    output logic                 rd_done,
    output logic [WIDTH-1:0]     rd_data,

    output logic [WIDTH-1:0]     d,
    output logic [RF_ADDR_W-1:0] wa,
    output logic                 nwe,
    output logic [RF_ADDR_W-1:0] ra,
    output logic                 nre,
    input  logic [WIDTH-1:0]     q
);

    wr_state_e w_state_q, w_state_d;
    rd_state_e r_state_q, r_state_d;

    logic [WIDTH-1:0]     d_q, d_d;
    logic [RF_ADDR_W-1:0] wa_q, wa_d;
    logic                 nwe_q, nwe_d;
    logic                 wr_ready_q, wr_ready_d;

    logic [RF_ADDR_W-1:0] ra_q, ra_d;
    logic                 nre_q, nre_d;
    logic                 rd_ready_q, rd_ready_d;
    logic                 rd_done_q, rd_done_d;
    logic [WIDTH-1:0]     rd_data_q, rd_data_d;

    logic               w_load, w_zero;
    logic [TIMER_W-1:0] w_load_val;
    logic               r_load, r_zero;
    logic [TIMER_W-1:0] r_load_val;

    logic wr_accept;
    logic rd_hazard;

    regfile_seq_timer u_wr_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    regfile_seq_timer u_rd_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (r_load),
        .load_val (r_load_val),
        .zero     (r_zero)
    );

    assign wr_accept = (w_state_q == W_IDLE) && wr_valid;

    // A read must not overlap a write in flight to its register, including one accepted this cycle.
    assign rd_hazard = ((w_state_q != W_IDLE) && (wa_q == rd_addr)) ||
                       (wr_accept && (wr_addr == rd_addr));

    always_comb begin
        w_state_d  = w_state_q;
        wa_d       = wa_q;
        d_d        = d_q;
        w_load     = 1'b0;
        w_load_val = '0;
        unique case (w_state_q)
            W_IDLE: begin
                if (wr_valid) begin
                    w_state_d  = W_SETUP;
                    wa_d       = wr_addr;
                    d_d        = wr_data;
                    w_load     = 1'b1;
                    w_load_val = cycles_to_load(SETUP);
                end
            end
            W_SETUP: begin
                if (w_zero) begin
                    w_state_d  = W_PULSE;
                    w_load     = 1'b1;
                    w_load_val = cycles_to_load(PULSE);
                end
            end
            W_PULSE: begin
                if (w_zero) begin
                    w_state_d  = W_HOLD;
                    w_load     = 1'b1;
                    w_load_val = cycles_to_load(HOLD);
                end
            end
            W_HOLD: begin
                if (w_zero) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        // Pin levels follow the next state so they come straight from flops.
        nwe_d      = (w_state_d != W_PULSE);
        wr_ready_d = (w_state_d == W_IDLE);
    end

    always_comb begin
        r_state_d  = r_state_q;
        ra_d       = ra_q;
        rd_data_d  = rd_data_q;
        r_load     = 1'b0;
        r_load_val = cycles_to_load(ACCESS);
        unique case (r_state_q)
            R_IDLE: begin
                if (rd_valid) begin
                    ra_d = rd_addr;
                    if (rd_hazard) begin
                        r_state_d = R_STALL;
                    end else begin
                        r_state_d = R_ACCESS;
                        r_load    = 1'b1;
                    end
                end
            end
            R_STALL: begin
                if (w_state_q == W_IDLE) begin
                    r_state_d = R_ACCESS;
                    r_load    = 1'b1;
                end
            end
            R_ACCESS: begin
                if (r_zero) begin
                    r_state_d = R_DONE;
                    rd_data_d = q;
                end
            end
            R_DONE: begin
                r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        nre_d      = (r_state_d != R_ACCESS);
        rd_ready_d = (r_state_d == R_IDLE);
        rd_done_d  = (r_state_d == R_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q  <= W_IDLE;
            wa_q       <= '0;
            d_q        <= '0;
            nwe_q      <= 1'b1;
            wr_ready_q <= 1'b1;
            r_state_q  <= R_IDLE;
            ra_q       <= '0;
            nre_q      <= 1'b1;
            rd_ready_q <= 1'b1;
            rd_done_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            w_state_q  <= w_state_d;
            wa_q       <= wa_d;
            d_q        <= d_d;
            nwe_q      <= nwe_d;
            wr_ready_q <= wr_ready_d;
            r_state_q  <= r_state_d;
            ra_q       <= ra_d;
            nre_q      <= nre_d;
            rd_ready_q <= rd_ready_d;
            rd_done_q  <= rd_done_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign d        = d_q;
    assign wa       = wa_q;
    assign nwe      = nwe_q;
    assign wr_ready = wr_ready_q;
    assign ra       = ra_q;
    assign nre      = nre_q;
    assign rd_ready = rd_ready_q;
    assign rd_done  = rd_done_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Self-checking bench for regfile_seq driving a behavioural 16-bit bank built from
// four 4x4 '670 slices; expectations come from a register array and timing formulas.
module tb_regfile_seq;
    import regfile_seq_pkg::*;

    localparam int WIDTH  = 16;
    localparam int SETUP  = DEF_SETUP;
    localparam int PULSE  = DEF_PULSE;
    localparam int HOLD   = DEF_HOLD;
    localparam int ACCESS = DEF_ACCESS;
    localparam int WR_CYC = SETUP + PULSE + HOLD;

    logic                 clk;
    logic                 reset;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [RF_ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [RF_ADDR_W-1:0] rd_addr;
    logic                 rd_done;
    logic [WIDTH-1:0]     rd_data;
    logic [WIDTH-1:0]     d;
    logic [RF_ADDR_W-1:0] wa;
    logic                 nwe;
    logic [RF_ADDR_W-1:0] ra;
    logic                 nre;
    logic [WIDTH-1:0]     q;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [WIDTH-1:0] ref_mem [4];

    regfile_seq #(
        .WIDTH  (WIDTH),
        .SETUP  (SETUP),
        .PULSE  (PULSE),
        .HOLD   (HOLD),
        .ACCESS (ACCESS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_addr  (rd_addr),
        .rd_done  (rd_done),
        .rd_data  (rd_data),
        .d        (d),
        .wa       (wa),
        .nwe      (nwe),
        .ra       (ra),
        .nre      (nre),
        .q        (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank: four 4-bit slices, transparent write while nwe is low, q unknown while nre is high.
    logic [3:0]       bank_mem [4][4];
    logic [WIDTH-1:0] bank_q;

    always @(nwe or wa or d) begin
        if (!nwe) begin
            for (int s = 0; s < 4; s++) bank_mem[s][wa] = d[4*s +: 4];
        end
    end

    always_comb begin
        bank_q = '0;
        for (int s = 0; s < 4; s++) bank_q[4*s +: 4] = bank_mem[s][ra];
    end

    assign q = nre ? 'x : bank_q;

    task automatic wait_ready(input bit need_wr, input bit need_rd);
        int n = 0;
        @(negedge clk);
        while (((need_wr && !wr_ready) || (need_rd && !rd_ready)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL ready_timeout wr_ready=%b rd_ready=%b after %0d cycles", wr_ready, rd_ready, n);
        end
    endtask

    // Presents the requests at a negedge; k is the index of the accepting edge.
    task automatic issue(input bit do_wr, input logic [1:0] wad, input logic [WIDTH-1:0] wdat,
                         input bit do_rd, input logic [1:0] rad, output int k);
        wait_ready(do_wr, do_rd);
        wr_valid = do_wr;
        wr_addr  = wad;
        wr_data  = wdat;
        rd_valid = do_rd;
        rd_addr  = rad;
        @(posedge clk);
        #1;
        k        = cyc;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic wait_done(output int kd, output logic [WIDTH-1:0] data);
        int n = 0;
        @(negedge clk);
        while (!rd_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        kd   = rd_done ? cyc : -1;
        data = rd_data;
        checks++;
        if (!rd_done) begin
            failures++;
            $display("FAIL rd_done_timeout no strobe within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({nwe, nre, wr_ready, rd_ready, rd_done} !== 5'b11110) begin
            failures++;
            $display("FAIL reset_ctrl nwe/nre/wr_ready/rd_ready/rd_done got=%b exp=11110",
                     {nwe, nre, wr_ready, rd_ready, rd_done});
        end
        checks++;
        if (wa !== 2'd0 || ra !== 2'd0 || d !== '0 || rd_data !== '0) begin
            failures++;
            $display("FAIL reset_data wa=%0d ra=%0d d=%h rd_data=%h exp all zero", wa, ra, d, rd_data);
        end
    endtask

    task automatic test_write_read();
        int k, kd, off;
        logic [WIDTH-1:0] data;
        issue(1'b1, 2'd2, 16'hBEEF, 1'b0, 2'd0, k);
        ref_mem[2] = 16'hBEEF;
        for (int i = 0; i <= WR_CYC; i++) begin
            @(negedge clk);
            off = cyc - k;
            checks++;
            if (nwe !== !(off >= SETUP && off < SETUP + PULSE)) begin
                failures++;
                $display("FAIL wr_nwe_timing offset=%0d got=%b", off, nwe);
            end
            if (off < WR_CYC) begin
                checks++;
                if (wa !== 2'd2 || d !== 16'hBEEF) begin
                    failures++;
                    $display("FAIL wr_addr_stable offset=%0d wa=%0d d=%h exp wa=2 d=beef", off, wa, d);
                end
            end
            checks++;
            if (wr_ready !== (off >= WR_CYC)) begin
                failures++;
                $display("FAIL wr_ready_timing offset=%0d got=%b", off, wr_ready);
            end
        end
        issue(1'b0, 2'd0, '0, 1'b1, 2'd2, k);
        wait_done(kd, data);
        checks++;
        if (data !== 16'hBEEF) begin
            failures++;
            $display("FAIL rd_beef got=%h exp=beef", data);
        end
        checks++;
        if (kd != k + ACCESS) begin
            failures++;
            $display("FAIL rd_latency got=%0d exp=%0d", kd - k, ACCESS);
        end
        @(negedge clk);
        checks++;
        if (rd_done !== 1'b0 || rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rd_done_strobe rd_done=%b rd_ready=%b exp 0/1", rd_done, rd_ready);
        end
    endtask

    task automatic test_concurrent_diff();
        int k, kd;
        logic [WIDTH-1:0] data;
        issue(1'b1, 2'd3, 16'hAAAA, 1'b0, 2'd0, k);
        ref_mem[3] = 16'hAAAA;
        issue(1'b1, 2'd0, 16'h1234, 1'b1, 2'd3, k);
        wait_done(kd, data);
        ref_mem[0] = 16'h1234;
        checks++;
        if (data !== 16'hAAAA) begin
            failures++;
            $display("FAIL conc_diff_data got=%h exp=aaaa", data);
        end
        checks++;
        if (kd != k + ACCESS) begin
            failures++;
            $display("FAIL conc_diff_latency got=%0d exp=%0d", kd - k, ACCESS);
        end
    endtask

    task automatic test_same_addr_stall();
        int k, kd, first_nre, last_nwe, n;
        logic [WIDTH-1:0] data;
        issue(1'b1, 2'd1, 16'h0F0F, 1'b0, 2'd0, k);
        ref_mem[1] = 16'h0F0F;
        issue(1'b1, 2'd1, 16'h5A5A, 1'b1, 2'd1, k);
        first_nre = -1;
        last_nwe  = -1;
        n = 0;
        kd = -1;
        data = '0;
        while (n < 40 && kd < 0) begin
            @(negedge clk);
            if (!nwe) last_nwe = cyc - k;
            if (!nre && first_nre < 0) first_nre = cyc - k;
            if (rd_done) begin
                kd   = cyc;
                data = rd_data;
            end
            n++;
        end
        ref_mem[1] = 16'h5A5A;
        checks++;
        if (data !== 16'h5A5A) begin
            failures++;
            $display("FAIL stall_data got=%h exp=5a5a", data);
        end
        checks++;
        if (first_nre != WR_CYC + 1 || first_nre <= last_nwe + HOLD) begin
            failures++;
            $display("FAIL stall_nre_fall got=%0d exp=%0d (last nwe low at %0d)", first_nre, WR_CYC + 1, last_nwe);
        end
        checks++;
        if (kd < 0 || kd != k + ACCESS + WR_CYC + 1) begin
            failures++;
            $display("FAIL stall_latency got=%0d exp=%0d", (kd < 0) ? -1 : kd - k, ACCESS + WR_CYC + 1);
        end
    endtask

    task automatic test_back_to_back();
        int k, k_prev, kd;
        logic [WIDTH-1:0] data;
        k_prev = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 2'(i), WIDTH'(1 << i), 1'b0, 2'd0, k);
            ref_mem[i] = WIDTH'(1 << i);
            if (i > 0) begin
                checks++;
                if (k - k_prev != WR_CYC + 1) begin
                    failures++;
                    $display("FAIL b2b_interval write=%0d got=%0d exp=%0d", i, k - k_prev, WR_CYC + 1);
                end
            end
            k_prev = k;
        end
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 2'd0, '0, 1'b1, 2'(i), k);
            wait_done(kd, data);
            checks++;
            if (data !== ref_mem[i]) begin
                failures++;
                $display("FAIL b2b_readback reg=%0d got=%h exp=%h", i, data, ref_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k, n, kd;
        logic [WIDTH-1:0] data;
        bit seen_done;
        issue(1'b1, 2'd3, 16'h1357, 1'b1, 2'd0, k);
        n = 0;
        @(negedge clk);
        while (nwe && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (nwe !== 1'b1 || nre !== 1'b1) begin
            failures++;
            $display("FAIL reset_async_pins nwe=%b nre=%b exp 1/1", nwe, nre);
        end
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rd_done) seen_done = 1'b1;
        end
        checks++;
        if (wr_ready !== 1'b1 || rd_ready !== 1'b1 || seen_done) begin
            failures++;
            $display("FAIL reset_mid_idle wr_ready=%b rd_ready=%b rd_done_seen=%b exp 1/1/0",
                     wr_ready, rd_ready, seen_done);
        end
        issue(1'b1, 2'd3, 16'hFFFF, 1'b0, 2'd0, k);
        ref_mem[3] = 16'hFFFF;
        issue(1'b0, 2'd0, '0, 1'b1, 2'd3, k);
        wait_done(kd, data);
        checks++;
        if (data !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_then_write got=%h exp=ffff", data);
        end
    endtask

    task automatic test_x_on_q();
        int k, n;
        bit went_x;
        issue(1'b0, 2'd0, '0, 1'b1, 2'd0, k);
        went_x = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rd_done && n < 20) begin
            if ($isunknown(rd_data)) went_x = 1'b1;
            @(negedge clk);
            n++;
        end
        if ($isunknown(rd_data)) went_x = 1'b1;
        checks++;
        if (went_x || rd_data !== ref_mem[0] || !rd_done) begin
            failures++;
            $display("FAIL x_on_q rd_data=%h exp=%h x_seen=%b", rd_data, ref_mem[0], went_x);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ($isunknown(rd_data) || rd_data !== ref_mem[0]) begin
                failures++;
                $display("FAIL x_on_q_hold rd_data=%h exp=%h", rd_data, ref_mem[0]);
            end
        end
    endtask

    task automatic test_random();
        int k, kd, mode, exp_lat;
        logic [1:0] wad, rad;
        logic [WIDTH-1:0] wdat, exp_data, data;
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 2));
            wad  = 2'($urandom_range(0, 3));
            rad  = 2'($urandom_range(0, 3));
            wdat = WIDTH'($urandom);
            wait_ready(1'b1, 1'b1);
            if (mode == 0) begin
                issue(1'b1, wad, wdat, 1'b0, 2'd0, k);
                ref_mem[wad] = wdat;
            end else begin
                if (mode == 1) begin
                    issue(1'b0, 2'd0, '0, 1'b1, rad, k);
                    exp_data = ref_mem[rad];
                    exp_lat  = ACCESS;
                end else begin
                    issue(1'b1, wad, wdat, 1'b1, rad, k);
                    exp_data = (wad == rad) ? wdat : ref_mem[rad];
                    exp_lat  = (wad == rad) ? ACCESS + WR_CYC + 1 : ACCESS;
                    ref_mem[wad] = wdat;
                end
                wait_done(kd, data);
                checks++;
                if (data !== exp_data || kd != k + exp_lat) begin
                    failures++;
                    $display("FAIL random it=%0d mode=%0d wa=%0d ra=%0d got=%h lat=%0d exp=%h lat=%0d",
                             it, mode, wad, rad, data, kd - k, exp_data, exp_lat);
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_valid = 1'b0;
        rd_addr  = '0;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        test_reset();
        test_write_read();
        test_concurrent_diff();
        test_same_addr_stall();
        test_back_to_back();
        test_reset_mid();
        test_x_on_q();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
